// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub.
// The master drives operands and out_ready; the slave (the adder) drives results.
interface pipe_addsub_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, zero
  );
endinterface

// File: rtl/pipe_addsub.sv
// pipe_addsub: STAGES-deep chunked adder/subtractor; the carry is registered between chunks.
// Optional signed saturation of the result is enabled by defining PIPE_ADDSUB_SAT_EN.
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic          clk,
  input logic          rst,
  pipe_addsub_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [WIDTH-1:0]  a_d  [STAGES];
  logic [WIDTH-1:0]  eb_q [STAGES];
  logic [WIDTH-1:0]  eb_d [STAGES];
  logic [WIDTH-1:0]  s_q  [STAGES];
  logic [WIDTH-1:0]  s_d  [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] c_d;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;

  logic             adv;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] eb_in;
  logic [WIDTH-1:0] s_in;
  logic             c_in;
  logic             v_in;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] res_sum;
  logic             a_msb;
  logic             eb_msb;
  logic             ovf;

  // The whole pipe moves together; it only holds when the final stage is full and not taken.
  assign adv = !v_q[STAGES-1] || bus.out_ready;

  // Next state of every stage: add chunk k using the carry left by stage k-1, or hold.
  always_comb begin
    a_in      = '0;
    eb_in     = '0;
    s_in      = '0;
    c_in      = 1'b0;
    v_in      = 1'b0;
    chunk_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        a_in  = bus.a;
        eb_in = bus.sub ? ~bus.b : bus.b;
        c_in  = bus.sub ? ~bus.carry_in : bus.carry_in;
        s_in  = '0;
        v_in  = bus.in_valid;
      end else begin
        a_in  = a_q[k-1];
        eb_in = eb_q[k-1];
        c_in  = c_q[k-1];
        s_in  = s_q[k-1];
        v_in  = v_q[k-1];
      end
      chunk_sum = {1'b0, a_in[k*CHUNK +: CHUNK]} + {1'b0, eb_in[k*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, c_in};
      if (adv) begin
        a_d[k]                  = a_in;
        eb_d[k]                 = eb_in;
        s_d[k]                  = s_in;
        s_d[k][k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        c_d[k]                  = chunk_sum[CHUNK];
        v_d[k]                  = v_in;
      end else begin
        a_d[k]  = a_q[k];
        eb_d[k] = eb_q[k];
        s_d[k]  = s_q[k];
        c_d[k]  = c_q[k];
        v_d[k]  = v_q[k];
      end
    end
  end

  // Stage registers; reset discards everything in flight and zeroes the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= '0;
        eb_q[k] <= '0;
        s_q[k]  <= '0;
      end
      c_q <= '0;
      v_q <= '0;
    end else begin
      a_q  <= a_d;
      eb_q <= eb_d;
      s_q  <= s_d;
      c_q  <= c_d;
      v_q  <= v_d;
    end
  end

  // Flags are derived from the final stage register; operand MSBs ride along for overflow.
  assign raw_sum = s_q[STAGES-1];
  assign a_msb   = a_q[STAGES-1][WIDTH-1];
  assign eb_msb  = eb_q[STAGES-1][WIDTH-1];
  assign ovf     = (a_msb == eb_msb) && (raw_sum[WIDTH-1] != a_msb);

`ifdef PIPE_ADDSUB_SAT_EN
  assign res_sum = ovf ? {a_msb, {(WIDTH-1){~a_msb}}} : raw_sum;
`else
  assign res_sum = raw_sum;
`endif

  assign bus.in_ready  = adv;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = res_sum;
  assign bus.carry_out = c_q[STAGES-1];
  assign bus.overflow  = ovf;
  assign bus.zero      = (res_sum == '0);
endmodule
